// File: rtl/rx_ctrl.sv
// rtl/rx_ctrl.sv - serial receiver sequencer with byte FIFO, error counter and overflow flag
module rx_ctrl #(
  parameter int DEPTH     = 4,
  parameter int ERR_W     = 8,
  parameter bit STORE_ERR = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_ctrl_enable,
  input  logic                       i_clear_status,
  output logic                       o_rx_en,
  input  logic [7:0]                 i_rx_data_in,
  input  logic                       i_rx_busy,
  input  logic                       i_rx_ready,
  input  logic                       i_rx_error,
  output logic                       o_rx_data_ack,
  output logic [7:0]                 o_m_data,
  output logic                       o_m_valid,
  input  logic                       i_m_ready,
  output logic [$clog2(DEPTH):0]     o_fifo_count,
  output logic [ERR_W-1:0]           o_err_count,
  output logic                       o_overflow,
  output logic                       o_active
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_DISABLED, S_WAIT, S_CAPTURE, S_ACK} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_rx_en;
  logic              r_ack;
  logic [7:0]        r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic [ERR_W-1:0]  r_err_count;
  logic              r_overflow;
  logic              w_capture;
  logic              w_pop;
  logic              w_room;
  logic              w_push;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_DISABLED;
    else          r_state <= w_state_nxt;
  end

  // Next-state and receiver enable; disable waits for the receiver to go idle
  always_comb begin
    w_state_nxt = r_state;
    w_rx_en     = 1'b1;
    case (r_state)
      S_DISABLED: begin
        w_rx_en = 1'b0;
        if (i_ctrl_enable) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_rx_ready)                         w_state_nxt = S_CAPTURE;
        else if (!i_ctrl_enable && !i_rx_busy)  w_state_nxt = S_DISABLED;
      end
      S_CAPTURE: w_state_nxt = S_ACK;
      S_ACK: begin
        if (!i_rx_ready) w_state_nxt = i_ctrl_enable ? S_WAIT : S_DISABLED;
      end
      default: w_state_nxt = S_DISABLED;
    endcase
  end

  // Ack is high exactly while the FSM sits in ACK
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_ack <= 1'b0;
    else          r_ack <= (w_state_nxt == S_ACK);
  end

  assign w_capture = (r_state == S_CAPTURE);
  assign w_pop     = (r_count != '0) && i_m_ready;
  assign w_room    = (r_count < C_FULL) || w_pop;
  assign w_push    = w_capture && w_room && (!i_rx_error || STORE_ERR);

  // FIFO storage; cleared on reset so the empty head reads as zero
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (w_push) begin
      r_mem[r_wptr] <= i_rx_data_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating framing-error counter; clear has priority over increment
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear_status)
      r_err_count <= '0;
    else if (w_capture && i_rx_error && !(&r_err_count))
      r_err_count <= r_err_count + ERR_W'(1);
  end

  // Sticky overflow: a good byte found no room; clear has priority
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear_status)
      r_overflow <= 1'b0;
    else if (w_capture && !i_rx_error && !w_room)
      r_overflow <= 1'b1;
  end

  assign o_rx_en       = w_rx_en;
  assign o_rx_data_ack = r_ack;
  assign o_m_data      = r_mem[r_rptr];
  assign o_m_valid     = (r_count != '0);
  assign o_fifo_count  = r_count;
  assign o_err_count   = r_err_count;
  assign o_overflow    = r_overflow;
  assign o_active      = (r_state != S_DISABLED);

endmodule

// File: tb/tb_rx_ctrl.sv
// tb/tb_rx_ctrl.sv - scoreboard bench for rx_ctrl
module tb_rx_ctrl;

  localparam int DEPTH     = 4;
  localparam int ERR_W     = 8;
  localparam bit STORE_ERR = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n, ctrl_enable, clear_status;
  logic       rx_en, rx_busy, rx_ready, rx_error, rx_data_ack;
  logic [7:0] rx_data_in, m_data;
  logic       m_valid, m_ready, overflow, active;
  logic [2:0] fifo_count;
  logic [7:0] err_count;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         exp_err = 0;
  logic       exp_ovf = 1'b0;

  rx_ctrl #(.DEPTH(DEPTH), .ERR_W(ERR_W), .STORE_ERR(STORE_ERR)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ctrl_enable(ctrl_enable),
    .i_clear_status(clear_status), .o_rx_en(rx_en), .i_rx_data_in(rx_data_in),
    .i_rx_busy(rx_busy), .i_rx_ready(rx_ready), .i_rx_error(rx_error),
    .o_rx_data_ack(rx_data_ack), .o_m_data(m_data), .o_m_valid(m_valid),
    .i_m_ready(m_ready), .o_fifo_count(fifo_count), .o_err_count(err_count),
    .o_overflow(overflow), .o_active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop side of the scoreboard: sample just before each rising edge
  always @(negedge clk) begin
    logic [7:0] e;
    #4;
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) check("pop_unexpected", m_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("pop_data", m_data, e);
      end
    end
  end

  // One receiver frame; caller starts at a negedge with the FSM in WAIT
  task automatic send(input logic [7:0] d, input logic e, input int nbusy,
                      input logic popc, input logic clr, input logic dis);
    logic room;
    for (int k = 0; k < nbusy; k++) begin
      rx_busy = 1'b1;
      if (dis && k == 0) ctrl_enable = 1'b0;
      @(negedge clk);
    end
    if (dis) check("rx_en_while_busy", rx_en, 1);
    rx_busy = 1'b0; rx_ready = 1'b1; rx_data_in = d; rx_error = e;
    @(negedge clk);
    m_ready = popc; clear_status = clr;
    room = (exp_q.size() < DEPTH) || (popc && exp_q.size() > 0);
    if (e) begin
      if (exp_err != (1 << ERR_W) - 1) exp_err++;
      if (STORE_ERR && room) exp_q.push_back(d);
    end else if (room) exp_q.push_back(d);
    else exp_ovf = 1'b1;
    if (clr) begin exp_err = 0; exp_ovf = 1'b0; end
    @(negedge clk);
    m_ready = 1'b0; clear_status = 1'b0;
    check("ack_high", rx_data_ack, 1);
    @(negedge clk);
    check("ack_hold", rx_data_ack, 1);
    rx_ready = 1'b0; rx_error = 1'b0;
    @(negedge clk);
    check("ack_low", rx_data_ack, 0);
    check("err_count", err_count, exp_err);
    check("overflow", overflow, exp_ovf);
    check("fifo_count", fifo_count, exp_q.size());
  endtask

  task automatic drain();
    int n = 0;
    m_ready = 1'b1;
    while (m_valid && n < 20) begin @(negedge clk); n++; end
    m_ready = 1'b0;
    check("drain_empty", m_valid, 0);
    check("drain_left", exp_q.size(), 0);
    check("drain_count", fifo_count, 0);
  endtask

  initial begin
    rst_n = 1'b0; ctrl_enable = 1'b0; clear_status = 1'b0; rx_busy = 1'b0;
    rx_ready = 1'b0; rx_error = 1'b0; rx_data_in = 8'h00; m_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_rx_en", rx_en, 0);
    check("rst_ack", rx_data_ack, 0);
    check("rst_valid", m_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_data", m_data, 0);
    check("rst_err", err_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_active", active, 0);

    rst_n = 1'b1; ctrl_enable = 1'b1;
    @(negedge clk);
    check("en_active", active, 1);
    check("en_rx_en", rx_en, 1);
    send(8'hA5, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    check("a5_data", m_data, 8'hA5);
    check("a5_valid", m_valid, 1);

    send(8'h3C, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    check("err_one", err_count, 1);
    for (int i = 0; i < 256; i++) send(8'(i), 1'b1, 0, 1'b0, 1'b0, 1'b0);
    check("err_sat", err_count, 255);
    drain();

    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 1, 1'b0, 1'b0, 1'b0);
    check("full_count", fifo_count, 4);
    check("full_ovf", overflow, 1);
    drain();

    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0; exp_err = 0; exp_ovf = 1'b0;
    check("clr_err", err_count, 0);
    check("clr_ovf", overflow, 0);

    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b0, 0, 1'b0, 1'b0, 1'b0);
    send(8'h77, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    check("pp_count", fifo_count, 4);
    check("pp_ovf", overflow, 0);
    drain();

    send(8'h5A, 1'b0, 3, 1'b0, 1'b0, 1'b1);
    check("dis_rx_en", rx_en, 0);
    check("dis_active", active, 0);
    @(negedge clk);
    check("dis_stay", active, 0);
    drain();
    check("dis_drain_active", active, 0);

    ctrl_enable = 1'b1;
    @(negedge clk);
    send(8'h21, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    send(8'h22, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    rx_ready = 1'b1; rx_data_in = 8'h23;
    @(negedge clk);
    exp_q.push_back(8'h23);
    @(negedge clk);
    check("ack_before_rst", rx_data_ack, 1);
    check("count_before_rst", fifo_count, 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_ack", rx_data_ack, 0);
    check("rst2_count", fifo_count, 0);
    check("rst2_valid", m_valid, 0);
    check("rst2_active", active, 0);
    exp_q.delete(); exp_err = 0; exp_ovf = 1'b0;
    rst_n = 1'b1; rx_ready = 1'b0;
    @(negedge clk);
    send(8'h31, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    check("pre_clr_err", err_count, 1);
    send(8'h32, 1'b1, 1, 1'b0, 1'b1, 1'b0);
    check("clr_wins", err_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_ctrl.md
Name: rx_ctrl

Overview:
Controller that sequences the 8-bit asynchronous serial receiver (rx) and decouples it from the downstream consumer. Drives the receiver enable and the rx_data_ack handshake. Buffers accepted bytes in a small FIFO exposed as a valid/ready stream. Keeps a framing-error counter and a sticky overflow flag for status readout.

Parameters:
DEPTH, 4, FIFO depth in bytes; power of two, minimum 2
ERR_W, 8, width of the saturating framing-error counter
STORE_ERR, 0, 1 = bytes flagged by rx_error are pushed to the FIFO; 0 = they are dropped

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
ctrl_enable  in  1  level; 1 = receive path running
clear_status  in  1  single-cycle pulse; clears err_count and overflow
rx_en  out  1  enable to receiver
rx_data_in  in  8  receiver parallel output (rx_po)
rx_busy  in  1  receiver busy
rx_ready  in  1  receiver result valid
rx_error  in  1  receiver framing error, qualified by rx_ready
rx_data_ack  out  1  acknowledge to receiver
m_data  out  8  FIFO head byte
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data when m_valid=1
fifo_count  out  log2(DEPTH)+1  current FIFO occupancy
err_count  out  ERR_W  framing errors seen, saturating
overflow  out  1  sticky; a good byte was dropped because the FIFO was full
active  out  1  1 when state is not DISABLED

Behaviour:
- Reset (rst_n=0 at posedge) values: state DISABLED, rx_en=0, rx_data_ack=0, FIFO empty (m_valid=0, fifo_count=0, m_data=0), err_count=0, overflow=0, active=0.
- FSM:
  - DISABLED: rx_en=0. If ctrl_enable=1, go to WAIT.
  - WAIT: rx_en=1. If rx_ready=1, go to CAPTURE. Else if ctrl_enable=0 and rx_busy=0, go to DISABLED. Disable is never honoured while rx_busy=1.
  - CAPTURE (1 cycle): rx_en=1. Samples rx_data_in and rx_error, performs the push decision, asserts rx_data_ack=1, then goes to ACK.
  - ACK: rx_en=1, rx_data_ack=1. Stays until rx_ready=0, then deasserts ack and goes to WAIT (or DISABLED if ctrl_enable=0).
- rx_data_ack is registered: high from the cycle after CAPTURE is entered until the cycle after rx_ready is seen low.
- Push decision in CAPTURE:
  - rx_error=1: err_count increments, saturating at all-ones. The byte is pushed only if STORE_ERR=1 and there is room; otherwise it is dropped and overflow is unaffected.
  - rx_error=0: if there is room, push the byte. If there is no room, drop it and set overflow=1.
- "Room" means fifo_count<DEPTH, or a pop happens in the same cycle (m_valid & m_ready). A simultaneous push and pop at full is legal and leaves the count unchanged.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH.
  - First-word fall-through: m_data always shows the head entry; m_valid = (fifo_count != 0).
  - Pop occurs on m_valid & m_ready. A pop when empty is ignored.
  - A pushed byte becomes visible on m_data/m_valid on the cycle after CAPTURE.
- clear_status: on the next edge, err_count=0 and overflow=0. If it coincides with an increment or overflow event, the clear wins.
- ctrl_enable=0 never flushes the FIFO. Draining continues while DISABLED.
- active = (state != DISABLED).

Test Plan:
- Reset, then ctrl_enable=1. Frame 0xA5 received cleanly -> rx_ready handshake completes, rx_data_ack drops after rx_ready falls, m_data=0xA5, m_valid=1, fifo_count=1, err_count=0.
- Receiver reports rx_error=1 with STORE_ERR=0 -> err_count=1, fifo_count unchanged, overflow=0. Repeat 256 errors with ERR_W=8 -> err_count holds at 255.
- m_ready=0, send 5 good bytes 0x01..0x05 with DEPTH=4 -> fifo_count=4, overflow=1, byte 0x05 dropped. Drain -> 0x01,0x02,0x03,0x04 in order.
- FIFO full and m_ready=1 in the same cycle as CAPTURE of 0x77 -> pop and push both occur, fifo_count stays 4, overflow stays 0, 0x77 appears last on drain.
- Deassert ctrl_enable while rx_busy=1 -> rx_en stays 1 until the frame completes and is acked, then goes to DISABLED with rx_en=0 and active=0. FIFO content still drains.
- Assert rst_n=0 while in ACK with 3 bytes buffered -> next cycle rx_data_ack=0, fifo_count=0, m_valid=0, state DISABLED. Pulse clear_status during an error capture -> err_count=0.
